// File: rtl/tetris_gpio.sv
// tetris_gpio: Avalon-MM GPIO slave with atomic set/clear outputs,
// synchronised inputs, edge capture and a maskable level interrupt.
module tetris_gpio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int          CW  = 3;
  localparam logic [CW-1:0] ARM = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    arm_q, arm_d;

  logic             wr;
  logic             armed;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd;

  assign wr    = chipselect & ~write_n;
  assign wdat  = WIDTH'(writedata);
  assign sync  = sync_q[SYNC_STAGES-1];
  assign rise  = sync & ~prev_q;
  assign fall  = ~sync & prev_q;
  assign armed = (arm_q == ARM);

  // Input synchroniser chain and the one-cycle-delayed copy for edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
    end
  end

  // Arm counter: saturates, holding off detection right after reset.
  always_comb begin
    arm_d = armed ? arm_q : arm_q + 1'b1;
  end

  // Edge selection, suppressed until the synchroniser has settled.
  always_comb begin
    det = '0;
    if (EDGE_TYPE == 0)      det = rise;
    else if (EDGE_TYPE == 1) det = fall;
    else                     det = rise | fall;
    if (!armed) det = '0;
  end

  // Register write decode; a new edge beats a same-cycle clear.
  always_comb begin
    dout_d = dout_q;
    mask_d = mask_q;
    clr    = '0;
    if (wr) begin
      case (address)
        3'd0:    dout_d = wdat;
        3'd2:    mask_d = wdat;
        3'd3:    clr    = wdat;
        3'd4:    dout_d = dout_q | wdat;
        3'd5:    dout_d = dout_q & ~wdat;
        default: ;
      endcase
    end
    cap_d = (cap_q & ~clr) | det;
  end

  // Architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= WIDTH'(RESET_VALUE);
      mask_q <= '0;
      cap_q  <= '0;
      arm_q  <= '0;
    end else begin
      dout_q <= dout_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      arm_q  <= arm_d;
    end
  end

  // Zero-wait read mux, zero-extended to the bus width.
  always_comb begin
    rd = '0;
    case (address)
      3'd0:    rd[WIDTH-1:0] = dout_q;
      3'd1:    rd[WIDTH-1:0] = sync;
      3'd2:    rd[WIDTH-1:0] = mask_q;
      3'd3:    rd[WIDTH-1:0] = cap_q;
      default: ;
    endcase
    readdata = rd;
  end

  assign out_port = dout_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_tetris_gpio.sv
// tb_tetris_gpio: table-driven and sequence checks of tetris_gpio
// across edge types and port widths, with an expectation queue.
`timescale 1ns/1ps
module tb_tetris_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic [4:0]  cs;
  logic        write_n;
  logic [31:0] writedata;

  logic [7:0]  in0, in1, in2;
  logic [31:0] in32;
  logic [0:0]  inw1;
  logic [7:0]  out0, out1, out2;
  logic [31:0] out32;
  logic [0:0]  outw1;
  logic [31:0] rd0, rd1, rd2, rd32, rdw1;
  logic        irq0, irq1, irq2, irq32, irqw1;

  always #10 clk = ~clk;

  tetris_gpio #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0),
                .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs[0]), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .in_port(in0), .out_port(out0), .irq(irq0));

  tetris_gpio #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(1),
                .SYNC_STAGES(2)) u1 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs[1]), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .in_port(in1), .out_port(out1), .irq(irq1));

  tetris_gpio #(.WIDTH(8), .RESET_VALUE(32'h0), .EDGE_TYPE(2),
                .SYNC_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs[2]), .write_n(write_n), .writedata(writedata),
    .readdata(rd2), .in_port(in2), .out_port(out2), .irq(irq2));

  tetris_gpio #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(0),
                .SYNC_STAGES(2)) u32 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs[3]), .write_n(write_n), .writedata(writedata),
    .readdata(rd32), .in_port(in32), .out_port(out32), .irq(irq32));

  tetris_gpio #(.WIDTH(1), .RESET_VALUE(32'h0), .EDGE_TYPE(0),
                .SYNC_STAGES(2)) uw1 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(cs[4]), .write_n(write_n), .writedata(writedata),
    .readdata(rdw1), .in_port(inw1), .out_port(outw1), .irq(irqw1));

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  eout;
    logic [31:0] erd;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic exp_push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got %h with no expectation", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] e,
                     input logic [31:0] act);
    exp_push(n, e);
    sb_pop(act);
  endtask

  task automatic bus_write(input logic [4:0] sel, input logic [2:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = sel;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    cs      = '0;
  endtask

  task automatic rd(input int inst, input logic [2:0] a,
                    output logic [31:0] d);
    address = a;
    #1;
    case (inst)
      0:       d = rd0;
      1:       d = rd1;
      2:       d = rd2;
      3:       d = rd32;
      default: d = rdw1;
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t        vt[8];
  logic [31:0] d;

  initial begin
    reset     = 1'b1;
    address   = '0;
    cs        = '0;
    write_n   = 1'b1;
    writedata = '0;
    in0  = 8'hFF;
    in1  = '0;
    in2  = '0;
    in32 = '0;
    inw1 = '0;

    vt[0] = '{3'd0, 32'h0000003C, 8'h3C, 32'h3C};
    vt[1] = '{3'd4, 32'h00000081, 8'hBD, 32'h00};
    vt[2] = '{3'd5, 32'h0000000C, 8'hB1, 32'h00};
    vt[3] = '{3'd0, 32'hFFFFFF00, 8'h00, 32'h00};
    vt[4] = '{3'd4, 32'hFFFFFF0F, 8'h0F, 32'h00};
    vt[5] = '{3'd1, 32'h00000055, 8'h0F, 32'hFF};
    vt[6] = '{3'd6, 32'h000000FF, 8'h0F, 32'h00};
    vt[7] = '{3'd5, 32'h00000003, 8'h0C, 32'h00};

    cyc(3);
    chk("rst_out", 32'hA5, 32'(out0));
    chk("rst_irq", 32'h0, 32'(irq0));
    rd(0, 3'd3, d); chk("rst_cap", 32'h0, d);
    rd(0, 3'd0, d); chk("rst_rd0", 32'hA5, d);
    @(negedge clk) reset = 1'b0;

    cyc(6);
    rd(0, 3'd3, d); chk("arm_nocap", 32'h0, d);
    rd(0, 3'd1, d); chk("din_ff", 32'hFF, d);

    @(negedge clk) in0 = 8'hFB;
    cyc(4);
    rd(0, 3'd3, d); chk("fall_nocap", 32'h0, d);

    @(negedge clk) in0 = 8'hFF;
    cyc(1);
    rd(0, 3'd1, d); chk("din_lat0", 32'hFB, d);
    cyc(1);
    rd(0, 3'd1, d); chk("din_lat1", 32'hFF, d);
    rd(0, 3'd3, d); chk("cap_early", 32'h0, d);
    cyc(1);
    rd(0, 3'd3, d); chk("cap_lat", 32'h04, d);
    chk("cap_irq_unmasked", 32'h0, 32'(irq0));

    for (int i = 0; i < 8; i++) begin
      exp_push($sformatf("vec%0d_out", i), 32'(vt[i].eout));
      exp_push($sformatf("vec%0d_rd", i), vt[i].erd);
      bus_write(5'b00001, vt[i].a, vt[i].d);
      sb_pop(32'(out0));
      rd(0, vt[i].a, d);
      sb_pop(d);
    end

    bus_write(5'b00001, 3'd3, 32'h04);
    rd(0, 3'd3, d); chk("cap_clr", 32'h0, d);
    bus_write(5'b00001, 3'd2, 32'h04);
    rd(0, 3'd2, d); chk("mask_rd", 32'h04, d);
    chk("irq_idle", 32'h0, 32'(irq0));

    @(negedge clk) in0 = 8'hFB;
    cyc(4);
    @(negedge clk) in0 = 8'hFF;
    cyc(3);
    chk("irq_set", 32'h1, 32'(irq0));
    bus_write(5'b00001, 3'd3, 32'h04);
    chk("irq_clr", 32'h0, 32'(irq0));

    @(negedge clk) in0 = 8'hFB;
    cyc(4);
    @(negedge clk) in0 = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    bus_write(5'b00001, 3'd3, 32'h04);
    rd(0, 3'd3, d); chk("coll_cap", 32'h04, d);
    chk("coll_irq", 32'h1, 32'(irq0));

    bus_write(5'b00001, 3'd2, 32'h00);
    chk("unmask_irq", 32'h0, 32'(irq0));
    rd(0, 3'd3, d); chk("unmask_keep", 32'h04, d);
    bus_write(5'b00001, 3'd2, 32'h04);
    chk("remask_irq", 32'h1, 32'(irq0));

    @(negedge clk);
    address   = 3'd0;
    writedata = 32'h12;
    write_n   = 1'b0;
    cs        = 5'b00001;
    #3 reset = 1'b1;
    #1;
    chk("mr_out", 32'hA5, 32'(out0));
    chk("mr_irq", 32'h0, 32'(irq0));
    write_n = 1'b1;
    cs      = '0;
    cyc(1);
    chk("mr_out_hold", 32'hA5, 32'(out0));
    rd(0, 3'd3, d); chk("mr_cap", 32'h0, d);
    rd(0, 3'd2, d); chk("mr_mask", 32'h0, d);
    @(negedge clk) reset = 1'b0;
    cyc(6);
    rd(0, 3'd3, d); chk("mr_arm_nocap", 32'h0, d);

    @(negedge clk) in2 = 8'h01;
    cyc(3);
    rd(2, 3'd3, d); chk("e2_rise", 32'h01, d);
    bus_write(5'b00100, 3'd3, 32'h01);
    rd(2, 3'd3, d); chk("e2_clr", 32'h0, d);
    @(negedge clk) in2 = 8'h00;
    cyc(3);
    rd(2, 3'd3, d); chk("e2_fall", 32'h01, d);

    @(negedge clk) in1 = 8'h01;
    cyc(3);
    rd(1, 3'd3, d); chk("e1_rise", 32'h0, d);
    @(negedge clk) in1 = 8'h00;
    cyc(3);
    rd(1, 3'd3, d); chk("e1_fall", 32'h01, d);

    @(negedge clk) in32 = 32'hDEADBEEF;
    cyc(2);
    rd(3, 3'd1, d); chk("w32_din", 32'hDEADBEEF, d);
    bus_write(5'b01000, 3'd0, 32'h12345678);
    chk("w32_out", 32'h12345678, out32);

    @(negedge clk) inw1 = 1'b1;
    cyc(2);
    rd(4, 3'd1, d); chk("w1_din", 32'h1, d);
    bus_write(5'b10000, 3'd0, 32'hFFFFFFFE);
    rd(4, 3'd0, d); chk("w1_rd0", 32'h0, d);
    bus_write(5'b10000, 3'd0, 32'h00000001);
    chk("w1_out", 32'h1, 32'(outw1));

    bus_write(5'b00001, 3'd0, 32'h5A);
    rd(0, 3'd6, d); chk("addr6", 32'h0, d);
    rd(0, 3'd7, d); chk("addr7", 32'h0, d);
    rd(0, 3'd0, d); chk("addr0_5a", 32'h5A, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
